// File: rtl/alu_pkg.sv
// ALU opcode encoding, register/data widths, pipeline payload types and flag mask helper.
package alu_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned ALUC_W  = 4;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [ALUC_W-1:0] ALUC_ADDU = 4'b0000;
    localparam logic [ALUC_W-1:0] ALUC_SUBU = 4'b0001;
    localparam logic [ALUC_W-1:0] ALUC_ADD  = 4'b0010;
    localparam logic [ALUC_W-1:0] ALUC_SUB  = 4'b0011;
    localparam logic [ALUC_W-1:0] ALUC_AND  = 4'b0100;
    localparam logic [ALUC_W-1:0] ALUC_OR   = 4'b0101;
    localparam logic [ALUC_W-1:0] ALUC_XOR  = 4'b0110;
    localparam logic [ALUC_W-1:0] ALUC_NOR  = 4'b0111;
    localparam logic [ALUC_W-1:0] ALUC_LUI  = 4'b1000;  // 1001 also decodes as lui
    localparam logic [ALUC_W-1:0] ALUC_SLTU = 4'b1010;
    localparam logic [ALUC_W-1:0] ALUC_SLT  = 4'b1011;
    localparam logic [ALUC_W-1:0] ALUC_SRA  = 4'b1100;
    localparam logic [ALUC_W-1:0] ALUC_SRL  = 4'b1101;
    localparam logic [ALUC_W-1:0] ALUC_SLL  = 4'b1110;  // 1111 also decodes as sll

    // Op captured in S1 with its (possibly forwarded) operands
    typedef struct packed {
        logic [ALUC_W-1:0] aluc;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [REG_W-1:0]  rd;
        logic              wen;
    } s1_t;

    // Result held in S2 and presented downstream
    typedef struct packed {
        logic [DATA_W-1:0] r;
        logic              zero;
        logic              carry;
        logic              negative;
        logic              overflow;
        logic [REG_W-1:0]  rd;
        logic              wen;
    } s2_t;

    typedef struct packed {
        logic carry;
        logic ovf;
    } flag_mask_t;

    // Which raw ALU flags are meaningful for a given opcode
    function automatic flag_mask_t flag_mask(input logic [ALUC_W-1:0] aluc);
        flag_mask_t m;
        m = '{carry: 1'b0, ovf: 1'b0};
        casez (aluc)
            ALUC_ADDU, ALUC_SUBU, ALUC_SLTU, ALUC_SRA, ALUC_SRL, 4'b111?: m.carry = 1'b1;
            ALUC_ADD, ALUC_SUB:                                          m.ovf   = 1'b1;
            default: ;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Upstream op channel, downstream result channel and status for ex_stage.
interface ex_stage_if;
    import alu_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [ALUC_W-1:0]   in_aluc;
    logic [DATA_W-1:0]   in_a;
    logic [DATA_W-1:0]   in_b;
    logic [REG_W-1:0]    in_src_a;
    logic [REG_W-1:0]    in_src_b;
    logic [REG_W-1:0]    in_rd;
    logic                in_wen;

    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_r;
    logic                out_zero;
    logic                out_carry;
    logic                out_negative;
    logic                out_overflow;
    logic [REG_W-1:0]    out_rd;
    logic                out_wen;

    logic                sticky_ovf;
    logic                ovf_clr;
    logic [DATA_W-1:0]   retired_cnt;

    modport master (
        output in_valid, in_aluc, in_a, in_b, in_src_a, in_src_b, in_rd, in_wen,
        output out_ready, ovf_clr,
        input  in_ready, out_valid, out_r, out_zero, out_carry, out_negative,
        input  out_overflow, out_rd, out_wen, sticky_ovf, retired_cnt
    );

    modport slave (
        input  in_valid, in_aluc, in_a, in_b, in_src_a, in_src_b, in_rd, in_wen,
        input  out_ready, ovf_clr,
        output in_ready, out_valid, out_r, out_zero, out_carry, out_negative,
        output out_overflow, out_rd, out_wen, sticky_ovf, retired_cnt
    );

endinterface

// File: rtl/alu.sv
// Combinational 32-bit ALU producing raw (unmasked) flags.
module alu
    import alu_pkg::*;
(
    input  logic [ALUC_W-1:0] aluc,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] r,
    output logic              zero,
    output logic              carry,
    output logic              negative,
    output logic              overflow
);

    logic [DATA_W:0]    ext;
    logic [SHAMT_W-1:0] sh;

    // Opcode decode; shifts move b by a[4:0] and carry holds the last bit shifted out
    always_comb begin
        r        = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        ext      = '0;
        sh       = a[SHAMT_W-1:0];
        casez (aluc)
            ALUC_ADDU, ALUC_ADD: begin
                ext      = {1'b0, a} + {1'b0, b};
                r        = ext[DATA_W-1:0];
                carry    = ext[DATA_W];
                overflow = (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
            end
            ALUC_SUBU, ALUC_SUB: begin
                ext      = {1'b0, a} - {1'b0, b};
                r        = ext[DATA_W-1:0];
                carry    = ext[DATA_W];
                overflow = (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
            end
            ALUC_AND: r = a & b;
            ALUC_OR:  r = a | b;
            ALUC_XOR: r = a ^ b;
            ALUC_NOR: r = ~(a | b);
            4'b100?:  r = {b[15:0], 16'h0000};
            ALUC_SLTU: begin
                r     = DATA_W'(a < b);
                carry = a < b;
            end
            ALUC_SLT: r = DATA_W'($signed(a) < $signed(b));
            ALUC_SRA: begin
                ext   = $signed({b, 1'b0}) >>> sh;
                r     = ext[DATA_W:1];
                carry = ext[0];
            end
            ALUC_SRL: begin
                ext   = {b, 1'b0} >> sh;
                r     = ext[DATA_W:1];
                carry = ext[0];
            end
            4'b111?: begin
                ext   = {1'b0, b} << sh;
                r     = ext[DATA_W-1:0];
                carry = ext[DATA_W];
            end
            default: r = '0;
        endcase
        zero     = (r == '0);
        negative = r[DATA_W-1];
    end

endmodule

// File: rtl/ex_stage.sv
// Two-register execute stage: S1 holds the op with forwarded operands, S2 holds the masked ALU result.
module ex_stage
    import alu_pkg::*;
#(
    parameter bit FWD_EN = 1'b1
) (
    input logic       clk,
    input logic       rst,
    ex_stage_if.slave bus
);

    logic              s1_valid;
    logic              s2_valid;
    s1_t               s1_q;
    s2_t               s2_q;
    logic              s1_adv;
    logic              s2_adv;
    logic              handshake;

    logic [DATA_W-1:0] alu_r;
    logic              alu_zero;
    logic              alu_carry;
    logic              alu_negative;
    logic              alu_overflow;
    flag_mask_t        mask;

    logic              s1_hit_a;
    logic              s1_hit_b;
    logic              s2_hit_a;
    logic              s2_hit_b;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;

    assign s2_adv      = !s2_valid || bus.out_ready;
    assign s1_adv      = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;
    assign handshake   = s2_valid && bus.out_ready;

    alu u_alu (
        .aluc     (s1_q.aluc),
        .a        (s1_q.a),
        .b        (s1_q.b),
        .r        (alu_r),
        .zero     (alu_zero),
        .carry    (alu_carry),
        .negative (alu_negative),
        .overflow (alu_overflow)
    );

    assign mask = flag_mask(s1_q.aluc);

    // Producer match per operand; r0 is hardwired and never forwarded
    assign s1_hit_a = FWD_EN && (bus.in_src_a != '0) && s1_valid && s1_q.wen && (bus.in_src_a == s1_q.rd);
    assign s1_hit_b = FWD_EN && (bus.in_src_b != '0) && s1_valid && s1_q.wen && (bus.in_src_b == s1_q.rd);
    assign s2_hit_a = FWD_EN && (bus.in_src_a != '0) && s2_valid && s2_q.wen && (bus.in_src_a == s2_q.rd);
    assign s2_hit_b = FWD_EN && (bus.in_src_b != '0) && s2_valid && s2_q.wen && (bus.in_src_b == s2_q.rd);

    // Operand select: youngest producer (S1) wins over S2, else the decode value
    always_comb begin
        fwd_a = bus.in_a;
        fwd_b = bus.in_b;
        if (s1_hit_a)      fwd_a = alu_r;
        else if (s2_hit_a) fwd_a = s2_q.r;
        if (s1_hit_b)      fwd_b = alu_r;
        else if (s2_hit_b) fwd_b = s2_q.r;
    end

    // S1 register: accept a new op whenever the slot can advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_q <= '{aluc: bus.in_aluc, a: fwd_a, b: fwd_b, rd: bus.in_rd, wen: bus.in_wen};
            end
        end
    end

    // S2 register: capture ALU result with opcode-masked carry/overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_q     <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_q <= '{r:        alu_r,
                          zero:     alu_zero,
                          carry:    alu_carry & mask.carry,
                          negative: alu_negative,
                          overflow: alu_overflow & mask.ovf,
                          rd:       s1_q.rd,
                          wen:      s1_q.wen};
            end
        end
    end

    // Retire bookkeeping: handshake counter (wraps) and sticky overflow with clear priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.retired_cnt <= '0;
            bus.sticky_ovf  <= 1'b0;
        end else begin
            if (handshake) begin
                bus.retired_cnt <= bus.retired_cnt + DATA_W'(1);
            end
            if (bus.ovf_clr) begin
                bus.sticky_ovf <= 1'b0;
            end else if (handshake && s2_q.overflow) begin
                bus.sticky_ovf <= 1'b1;
            end
        end
    end

    assign bus.out_valid    = s2_valid;
    assign bus.out_r        = s2_q.r;
    assign bus.out_zero     = s2_q.zero;
    assign bus.out_carry    = s2_q.carry;
    assign bus.out_negative = s2_q.negative;
    assign bus.out_overflow = s2_q.overflow;
    assign bus.out_rd       = s2_q.rd;
    assign bus.out_wen      = s2_q.wen;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: one forwarding instance and one non-forwarding instance share stimulus.
module tb_ex_stage;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst;

    ex_stage_if bus1 ();
    ex_stage_if bus2 ();

    ex_stage #(.FWD_EN(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    ex_stage #(.FWD_EN(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    always #5 clk = ~clk;

    // The non-forwarding copy sees exactly the same inputs
    assign bus2.in_valid  = bus1.in_valid;
    assign bus2.in_aluc   = bus1.in_aluc;
    assign bus2.in_a      = bus1.in_a;
    assign bus2.in_b      = bus1.in_b;
    assign bus2.in_src_a  = bus1.in_src_a;
    assign bus2.in_src_b  = bus1.in_src_b;
    assign bus2.in_rd     = bus1.in_rd;
    assign bus2.in_wen    = bus1.in_wen;
    assign bus2.out_ready = bus1.out_ready;
    assign bus2.ovf_clr   = bus1.ovf_clr;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp1[$];
    logic [31:0] exp2[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op, confirm it is accepted at the next edge and record expected results
    task automatic issue(input logic [3:0] aluc, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sa, input logic [4:0] sb, input logic [4:0] rd,
                         input logic wen, input logic [31:0] e1, input logic [31:0] e2);
        bus1.in_valid = 1'b1;
        bus1.in_aluc  = aluc;
        bus1.in_a     = a;
        bus1.in_b     = b;
        bus1.in_src_a = sa;
        bus1.in_src_b = sb;
        bus1.in_rd    = rd;
        bus1.in_wen   = wen;
        #1;
        check("accept", 32'(bus1.in_ready), 32'd1);
        exp1.push_back(e1);
        exp2.push_back(e2);
        step();
        bus1.in_valid = 1'b0;
    endtask

    // Single op from idle: check two-edge latency and masked flags
    task automatic run1(input logic [3:0] aluc, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ec, input logic ev,
                        input logic en, input logic ez);
        issue(aluc, a, b, 5'd0, 5'd0, 5'd3, 1'b1, er, er);
        check("lat_n1", 32'(bus1.out_valid), 32'd0);
        step();
        check("lat_n2", 32'(bus1.out_valid), 32'd1);
        check("r", bus1.out_r, er);
        check("carry", 32'(bus1.out_carry), 32'(ec));
        check("ovf", 32'(bus1.out_overflow), 32'(ev));
        check("neg", 32'(bus1.out_negative), 32'(en));
        check("zero", 32'(bus1.out_zero), 32'(ez));
        check("rd", 32'(bus1.out_rd), 32'd3);
        step();
    endtask

    // Scoreboard: every result handshake must match the next expected value, in order
    always @(negedge clk) begin
        if (!rst) begin
            if (bus1.out_valid && bus1.out_ready) begin
                if (exp1.size() == 0) check("extra_fwd", 32'd1, 32'd0);
                else                  check("r_fwd", bus1.out_r, exp1.pop_front());
            end
            if (bus2.out_valid && bus2.out_ready) begin
                if (exp2.size() == 0) check("extra_nofwd", 32'd1, 32'd0);
                else                  check("r_nofwd", bus2.out_r, exp2.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    logic [31:0] ops [4];
    int k;

    initial begin
        rst            = 1'b1;
        bus1.in_valid  = 1'b0;
        bus1.in_aluc   = '0;
        bus1.in_a      = '0;
        bus1.in_b      = '0;
        bus1.in_src_a  = '0;
        bus1.in_src_b  = '0;
        bus1.in_rd     = '0;
        bus1.in_wen    = 1'b0;
        bus1.out_ready = 1'b1;
        bus1.ovf_clr   = 1'b0;
        step();
        step();
        check("rst_valid", 32'(bus1.out_valid), 32'd0);
        check("rst_r", bus1.out_r, 32'd0);
        check("rst_cnt", bus1.retired_cnt, 32'd0);
        check("rst_sticky", 32'(bus1.sticky_ovf), 32'd0);
        rst = 1'b0;
        step();
        check("idle_ready", 32'(bus1.in_ready), 32'd1);

        // Signed overflow and sticky behaviour
        run1(ALUC_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
        check("sticky_set", 32'(bus1.sticky_ovf), 32'd1);
        check("cnt1", bus1.retired_cnt, 32'd1);
        bus1.ovf_clr = 1'b1;
        step();
        check("sticky_clr", 32'(bus1.sticky_ovf), 32'd0);
        bus1.ovf_clr = 1'b0;

        run1(ALUC_ADDU, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
        run1(ALUC_SUB,  32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);
        check("sticky_sub", 32'(bus1.sticky_ovf), 32'd1);
        bus1.ovf_clr = 1'b1;
        run1(ALUC_ADD,  32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
        check("clr_prio", 32'(bus1.sticky_ovf), 32'd0);
        bus1.ovf_clr = 1'b0;

        run1(ALUC_SUBU, 32'd1, 32'd2, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        run1(ALUC_SLTU, 32'd1, 32'd2, 32'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        run1(ALUC_AND,  32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        run1(ALUC_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        run1(ALUC_SRL,  32'd1, 32'h8000_0001, 32'h4000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
        run1(ALUC_SLL,  32'd4, 32'hF000_0001, 32'h0000_0010, 1'b1, 1'b0, 1'b0, 1'b0);
        run1(ALUC_LUI,  32'd0, 32'h0000_1234, 32'h1234_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        run1(ALUC_SRA,  32'd4, 32'h8000_0000, 32'hF800_0000, 1'b0, 1'b0, 1'b1, 1'b0);
        check("cnt12", bus1.retired_cnt, 32'd12);

        // Forward from S1 (back-to-back)
        issue(ALUC_ADDU, 32'd3, 32'd4, 5'd0, 5'd0, 5'd5, 1'b1, 32'd7, 32'd7);
        issue(ALUC_ADDU, 32'd0, 32'd10, 5'd5, 5'd0, 5'd6, 1'b1, 32'd17, 32'd10);
        // Forward from S2 (one bubble)
        issue(ALUC_ADDU, 32'd20, 32'd5, 5'd0, 5'd0, 5'd7, 1'b1, 32'd25, 32'd25);
        step();
        issue(ALUC_ADDU, 32'd1, 32'd0, 5'd0, 5'd7, 5'd9, 1'b1, 32'd26, 32'd1);
        // S1 beats S2 for the same register
        issue(ALUC_ADDU, 32'd100, 32'd0, 5'd0, 5'd0, 5'd8, 1'b1, 32'd100, 32'd100);
        issue(ALUC_ADDU, 32'd200, 32'd0, 5'd0, 5'd0, 5'd8, 1'b1, 32'd200, 32'd200);
        issue(ALUC_ADDU, 32'd0, 32'd1, 5'd8, 5'd0, 5'd9, 1'b1, 32'd201, 32'd1);
        // No forward without wen, and never from r0
        issue(ALUC_ADDU, 32'd50, 32'd0, 5'd0, 5'd0, 5'd10, 1'b0, 32'd50, 32'd50);
        issue(ALUC_ADDU, 32'd2, 32'd3, 5'd10, 5'd0, 5'd11, 1'b1, 32'd5, 32'd5);
        issue(ALUC_ADDU, 32'd5, 32'd5, 5'd0, 5'd0, 5'd0, 1'b1, 32'd10, 32'd10);
        issue(ALUC_ADDU, 32'd9, 32'd1, 5'd0, 5'd0, 5'd1, 1'b1, 32'd10, 32'd10);
        repeat (4) step();
        check("fwd_drain1", 32'(exp1.size()), 32'd0);
        check("fwd_drain2", 32'(exp2.size()), 32'd0);

        // Downstream stall with continuous upstream offers
        ops[0] = 32'd11; ops[1] = 32'd22; ops[2] = 32'd33; ops[3] = 32'd44;
        k = 0;
        bus1.out_ready = 1'b0;
        bus1.in_aluc   = ALUC_ADDU;
        bus1.in_b      = 32'd0;
        bus1.in_src_a  = 5'd0;
        bus1.in_src_b  = 5'd0;
        bus1.in_rd     = 5'd12;
        bus1.in_wen    = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bus1.in_valid = 1'b1;
            bus1.in_a     = ops[k];
            #1;
            if (bus1.in_ready && k < 4) begin
                exp1.push_back(ops[k]);
                exp2.push_back(ops[k]);
                k++;
            end
            step();
        end
        check("stall_acc", 32'(k), 32'd2);
        check("stall_rdy", 32'(bus1.in_ready), 32'd0);
        check("stall_hold", bus1.out_r, 32'd11);
        bus1.out_ready = 1'b1;
        for (int c = 0; c < 10 && k < 4; c++) begin
            bus1.in_valid = 1'b1;
            bus1.in_a     = ops[k];
            #1;
            if (bus1.in_ready) begin
                exp1.push_back(ops[k]);
                exp2.push_back(ops[k]);
                k++;
            end
            step();
        end
        bus1.in_valid = 1'b0;
        repeat (4) step();
        check("stall_all", 32'(k), 32'd4);
        check("stall_drain", 32'(exp1.size()), 32'd0);

        // Reset with ops in flight
        run1(ALUC_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
        issue(ALUC_ADDU, 32'd1, 32'd1, 5'd0, 5'd0, 5'd2, 1'b1, 32'd2, 32'd2);
        issue(ALUC_ADDU, 32'd2, 32'd2, 5'd0, 5'd0, 5'd2, 1'b1, 32'd4, 32'd4);
        bus1.in_valid = 1'b1;
        bus1.in_a     = 32'd3;
        bus1.in_b     = 32'd3;
        #1;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(bus1.out_valid), 32'd0);
        check("arst_cnt", bus1.retired_cnt, 32'd0);
        check("arst_sticky", 32'(bus1.sticky_ovf), 32'd0);
        check("arst_r", bus1.out_r, 32'd0);
        exp1.delete();
        exp2.delete();
        bus1.in_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        check("post_valid", 32'(bus1.out_valid), 32'd0);
        check("post_ready", 32'(bus1.in_ready), 32'd1);
        run1(ALUC_ADDU, 32'd3, 32'd3, 32'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_cnt", bus1.retired_cnt, 32'd1);
        repeat (3) step();
        check("end_drain1", 32'(exp1.size()), 32'd0);
        check("end_drain2", 32'(exp2.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter: FWD_EN, default 1, enables operand forwarding; when 0, operands are taken from in_a/in_b unmodified.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  upstream op valid.
REQ-005 in_ready  output  1  stage can accept an op this cycle.
REQ-006 in_aluc  input  4  ALU operation code, same encoding as alu.
REQ-007 in_a, in_b  input  32 each  operand values read by decode.
REQ-008 in_src_a, in_src_b  input  5 each  source register numbers of in_a/in_b.
REQ-009 in_rd, in_wen  input  5, 1  destination register and write enable.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 out_r  output  32  ALU result.
REQ-013 out_zero, out_carry, out_negative, out_overflow  output  1 each  masked flags.
REQ-014 out_rd, out_wen  output  5, 1  destination carried with result.
REQ-015 sticky_ovf  output  1  set by any retired op with out_overflow=1.
REQ-016 ovf_clr  input  1  synchronous clear of sticky_ovf.
REQ-017 retired_cnt  output  32  count of output handshakes.

Function
REQ-018 Two pipeline registers: S1 (captured op plus forwarded operands) and S2 (ALU result, flags, rd, wen), each with a valid bit.
REQ-019 s2_adv = !s2_valid | out_ready; s1_adv = !s1_valid | s2_adv; in_ready = s1_adv (combinational path from out_ready is permitted).
REQ-020 An op accepted at edge N (in_valid & in_ready) presents out_valid=1 from edge N+2 when unstalled; throughput is 1 op/cycle.
REQ-021 A stalled stage holds its contents; out_* stays stable while out_valid & !out_ready.
REQ-022 S1 feeds one combinational alu instance; S2 captures its r and flags when s2_adv & s1_valid.
REQ-023 Forwarding is evaluated at S1 capture: if in_src_x == S1.rd & S1.valid & S1.wen, use the current ALU result of S1; else if it matches S2 with valid & wen, use S2.r; else use in_x.
REQ-024 S1 match has priority over S2 match; register 0 is never forwarded, regardless of wen.
REQ-025 Producers that have already left S2 are not forwarded; upstream guarantees register-file bypass for these.
REQ-026 Flag masking: carry is passed only for aluc 0000, 0001, 1010, 1100, 1101, 111x; overflow is passed only for 0010 and 0011; all other cases drive 0.
REQ-027 zero and negative are passed for all opcodes.
REQ-028 retired_cnt increments by 1 on each out_valid & out_ready and wraps 0xFFFFFFFF -> 0.
REQ-029 sticky_ovf sets on a handshake with out_overflow=1. ovf_clr has priority over a same-cycle set.
REQ-030 in_valid is ignored when in_ready=0; upstream holds the op.

Reset
REQ-031 rst=1 forces asynchronously: S1/S2 valid=0, all data registers 0, out_* = 0, sticky_ovf=0, retired_cnt=0, in_ready=1 (after release).
REQ-032 Reset mid-operation discards in-flight ops without emitting them; the first accept after release behaves as from idle.

Structure
REQ-033 Package alu_pkg holds the aluc encoding constants, the carry/overflow mask function, and the register-index width (5).
REQ-034 The existing alu module is instantiated as the single sub-module; ex_stage adds only registers, forwarding, and control.

Verification
REQ-035 Assert rst during 3 in-flight ops -> out_valid=0 immediately; retired_cnt=0; after release, a new op appears 2 cycles after accept.
REQ-036 aluc=0010, a=0x7FFFFFFF, b=1 -> out_r=0x80000000, overflow=1, negative=1, carry=0; sticky_ovf=1 after the handshake.
REQ-037 Back-to-back ops: addu rd=5 (3+4), then addu src_a=5, in_a=0, b=10 -> second out_r=17; the same test with FWD_EN=0 gives out_r=10.
REQ-038 in_rd=0, wen=1 producer, then consumer src_a=0, in_a=9, b=1, addu -> out_r=10 (no forward).
REQ-039 out_ready=0 for 4 cycles with continuous in_valid -> exactly 2 ops accepted, in_ready=0 afterwards, no loss/duplication, order preserved.
REQ-040 sltu a=1, b=2 -> out_r=1, carry=1; and a=1, b=2 (aluc 0100) -> carry=0, overflow=0.
